// File: rtl/mem_bus_router.sv
// mem_bus_router: decodes CPU memory-bus accesses onto one of NUM_SLAVES
// slave ports by base/mask. Each slave can stretch an access with its busy
// line, and a watchdog aborts any access that stays busy too long.
// Unmapped or aborted accesses return DEFAULT_RDATA, pulse err_o, record
// the failing address and bump a saturating error counter.
module mem_bus_router #(
    parameter int                         NUM_SLAVES    = 3,
    parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE      = {32'h0040_0010, 32'h0040_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK      = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFC0_0000},
    parameter logic [31:0]                DEFAULT_RDATA = 32'hDEAD_BEEF,
    parameter int                         TIMEOUT       = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [31:0]                  m_addr_i,
    input  logic                         m_rstrb_i,
    input  logic [3:0]                   m_wmask_i,
    input  logic [31:0]                  m_wdata_i,
    output logic [31:0]                  m_rdata_o,
    output logic                         m_busy_o,
    output logic [31:0]                  s_addr_o,
    output logic [31:0]                  s_wdata_o,
    output logic [NUM_SLAVES-1:0]        s_rstrb_o,
    output logic [NUM_SLAVES*4-1:0]      s_wmask_o,
    input  logic [NUM_SLAVES*32-1:0]     s_rdata_i,
    input  logic [NUM_SLAVES-1:0]        s_busy_i,
    output logic                         err_o,
    output logic [31:0]                  err_addr_o,
    output logic [15:0]                  err_cnt_o
);

    // The select value NUM_SLAVES stands for "unmapped", so the select
    // register needs one code beyond the last slave index.
    localparam int               SEL_W    = $clog2(NUM_SLAVES + 1);
    localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(NUM_SLAVES);
    // The watchdog fires in the busy cycle that would take the counter to
    // TIMEOUT, so an access is held busy for at most TIMEOUT cycles.
    localparam logic [7:0]       CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   dec_sel;
    logic [31:0]        addr_q;
    logic [7:0]         cnt_q;
    logic [31:0]        err_addr_q;
    logic [15:0]        err_cnt_q;

    logic               sel_busy;
    logic [31:0]        sel_rdata;
    logic               mapped;
    logic               timeout_hit;
    logic               done;
    logic               abort;
    logic               req;
    logic               accept;

    assign s_addr_o   = m_addr_i;
    assign s_wdata_o  = m_wdata_i;
    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;

    // Address decode: scan from the top so the lowest matching index wins.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first; a path that leaves it unassigned would infer a latch.
        dec_sel = SEL_NONE;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr_i & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                dec_sel = SEL_W'(i);
            end
        end
    end

    // Pick the busy line and read data of the latched slave.
    always_comb begin
        sel_busy  = 1'b0;
        sel_rdata = DEFAULT_RDATA;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_busy  = s_busy_i[i];
                sel_rdata = s_rdata_i[i*32 +: 32];
            end
        end
    end

    assign mapped      = (sel_q != SEL_NONE);
    assign timeout_hit = sel_busy && (cnt_q == CNT_LAST);
    assign done        = (state_q == S_BUSY) && (!mapped || !sel_busy || timeout_hit);
    assign abort       = done && mapped && sel_busy;
    assign req         = m_rstrb_i || (|m_wmask_i);
    assign accept      = !rst_i && req && ((state_q == S_IDLE) || done);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples its inputs from before the edge.
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a completion cycle can accept a new request directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_BUSY;
            S_BUSY: if (done)   state_d = accept ? S_BUSY : S_IDLE;
            default:            state_d = S_IDLE;
        endcase
    end

    // Outputs: strobe steering, CPU handshake, read-data mux and error pulse.
    always_comb begin
        s_rstrb_o = '0;
        s_wmask_o = '0;
        if (accept && (dec_sel != SEL_NONE)) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (dec_sel == SEL_W'(i)) begin
                    s_rstrb_o[i]         = m_rstrb_i;
                    s_wmask_o[i*4 +: 4]  = m_wmask_i;
                end
            end
        end
        m_busy_o  = (state_q == S_BUSY) && !done;
        m_rdata_o = (mapped && !abort) ? sel_rdata : DEFAULT_RDATA;
        err_o     = done && (!mapped || abort);
    end

    // Transaction context: slave select, address and watchdog counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q  <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            sel_q  <= dec_sel;
            addr_q <= m_addr_i;
            cnt_q  <= '0;
        end else if ((state_q == S_BUSY) && sel_busy && !done) begin
            cnt_q  <= cnt_q + 8'd1;
        end
    end

    // Error bookkeeping: last failing address and a saturating count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else if (err_o) begin
            err_addr_q <= addr_q;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

endmodule
